// File: rtl/vram_arbiter.sv
// Single-port video RAM arbiter: bounded-burst video line fetch with priority,
// CPU/loader round-robin on the remaining slots, and a latency-matched read tag pipe.
module vram_arbiter #(
  parameter int AW        = 18,
  parameter int DW        = 16,
  parameter int RD_LAT    = 2,
  parameter int VID_BURST = 8
) (
  input  logic            clk_sys,
  input  logic            reset_n,
  input  logic            vid_start,
  input  logic [AW-1:0]   vid_base,
  input  logic [8:0]      vid_len,
  output logic            vid_busy,
  output logic            vid_rvalid,
  output logic [DW-1:0]   vid_rdata,
  output logic            vid_overrun,
  input  logic            cpu_req,
  input  logic            cpu_we,
  input  logic [DW/8-1:0] cpu_be,
  input  logic [AW-1:0]   cpu_addr,
  input  logic [DW-1:0]   cpu_wdata,
  output logic            cpu_ack,
  output logic            cpu_rvalid,
  output logic [DW-1:0]   cpu_rdata,
  input  logic            ld_req,
  input  logic [AW-1:0]   ld_addr,
  input  logic [DW-1:0]   ld_wdata,
  output logic            ld_ack,
  output logic [AW-1:0]   ram_addr,
  output logic            ram_we,
  output logic [DW/8-1:0] ram_be,
  output logic [DW-1:0]   ram_wdata,
  input  logic [DW-1:0]   ram_rdata
);

  localparam int BW = DW / 8;
  localparam int CW = $clog2(VID_BURST + 1);
  localparam logic [CW-1:0] BURST_MAX = CW'(VID_BURST);

  typedef enum logic [1:0] {TAG_NONE, TAG_VID, TAG_CPU} tag_e;
  typedef enum logic [1:0] {GNT_NONE, GNT_VID, GNT_CPU, GNT_LD} gnt_e;

  // Handshake: cpu_req/ld_req are level requests held until their one-cycle ack.
  // The ack is high in the cycle the command sits on ram_*, and the request is
  // masked during that cycle so a still-held request is never issued twice.
  logic [CW-1:0] burst_q, burst_d;
  logic          last_nv_q, last_nv_d;  // 1: loader took the last non-video slot
  logic [AW-1:0] vid_ptr_q, vid_ptr_d;
  logic [8:0]    vid_rem_q, vid_rem_d;
  logic          vid_ovr_q, vid_ovr_d;
  logic          cpu_ack_q, cpu_ack_d;
  logic          ld_ack_q, ld_ack_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic          ram_we_q, ram_we_d;
  logic [BW-1:0] ram_be_q, ram_be_d;
  logic [DW-1:0] ram_wdata_q, ram_wdata_d;
  tag_e          tag_q [RD_LAT+1];
  tag_e          tag_d [RD_LAT+1];

  gnt_e gnt;
  logic cpu_elig, ld_elig, vid_elig, vid_pending, vid_load;

  always_comb begin : arbitrate
    cpu_elig = cpu_req && !cpu_ack_q;
    ld_elig  = ld_req && !ld_ack_q;
    vid_elig = (vid_rem_q != '0);
    gnt      = GNT_NONE;
    if (vid_elig && (burst_q < BURST_MAX)) gnt = GNT_VID;
    else if (cpu_elig && ld_elig)          gnt = last_nv_q ? GNT_CPU : GNT_LD;
    else if (cpu_elig)                     gnt = GNT_CPU;
    else if (ld_elig)                      gnt = GNT_LD;
    else if (vid_elig)                     gnt = GNT_VID;
  end

  always_comb begin : busy_track
    vid_pending = 1'b0;
    for (int i = 0; i <= RD_LAT; i++) begin
      if (tag_q[i] == TAG_VID) vid_pending = 1'b1;
    end
    vid_busy = vid_elig || vid_pending;
    vid_load = vid_start && !vid_busy && (vid_len != '0);
  end

  always_comb begin : next_state
    burst_d     = '0;
    last_nv_d   = last_nv_q;
    vid_ptr_d   = vid_ptr_q;
    vid_rem_d   = vid_rem_q;
    vid_ovr_d   = vid_ovr_q || (vid_start && vid_busy);
    cpu_ack_d   = 1'b0;
    ld_ack_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_we_d    = 1'b0;
    ram_be_d    = ram_be_q;
    ram_wdata_d = ram_wdata_q;
    tag_d       = tag_q;
    tag_d[0]    = TAG_NONE;
    for (int i = 1; i <= RD_LAT; i++) tag_d[i] = tag_q[i-1];

    if (vid_load) begin
      vid_ptr_d = vid_base;
      vid_rem_d = vid_len;
    end

    unique case (gnt)
      GNT_VID: begin
        ram_addr_d = vid_ptr_q;
        ram_be_d   = '1;
        tag_d[0]   = TAG_VID;
        vid_ptr_d  = vid_ptr_q + AW'(1);
        vid_rem_d  = vid_rem_q - 9'd1;
        // A held request masked by its own ack still counts as waiting, so the
        // video run between two slots of a held requester is exactly VID_BURST.
        if (cpu_req || ld_req)
          burst_d = (burst_q == BURST_MAX) ? burst_q : burst_q + CW'(1);
      end
      GNT_CPU: begin
        cpu_ack_d   = 1'b1;
        last_nv_d   = 1'b0;
        ram_addr_d  = cpu_addr;
        ram_we_d    = cpu_we;
        ram_be_d    = cpu_be;
        ram_wdata_d = cpu_wdata;
        tag_d[0]    = cpu_we ? TAG_NONE : TAG_CPU;
      end
      GNT_LD: begin
        ld_ack_d    = 1'b1;
        last_nv_d   = 1'b1;
        ram_addr_d  = ld_addr;
        ram_we_d    = 1'b1;
        ram_be_d    = '1;
        ram_wdata_d = ld_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin : regs
    if (!reset_n) begin
      burst_q     <= '0;
      last_nv_q   <= 1'b1;
      vid_ptr_q   <= '0;
      vid_rem_q   <= '0;
      vid_ovr_q   <= 1'b0;
      cpu_ack_q   <= 1'b0;
      ld_ack_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_be_q    <= '0;
      ram_wdata_q <= '0;
      for (int i = 0; i <= RD_LAT; i++) tag_q[i] <= TAG_NONE;
    end else begin
      burst_q     <= burst_d;
      last_nv_q   <= last_nv_d;
      vid_ptr_q   <= vid_ptr_d;
      vid_rem_q   <= vid_rem_d;
      vid_ovr_q   <= vid_ovr_d;
      cpu_ack_q   <= cpu_ack_d;
      ld_ack_q    <= ld_ack_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_be_q    <= ram_be_d;
      ram_wdata_q <= ram_wdata_d;
      for (int i = 0; i <= RD_LAT; i++) tag_q[i] <= tag_d[i];
    end
  end

  assign vid_overrun = vid_ovr_q;
  assign cpu_ack     = cpu_ack_q;
  assign ld_ack      = ld_ack_q;
  assign ram_addr    = ram_addr_q;
  assign ram_we      = ram_we_q;
  assign ram_be      = ram_be_q;
  assign ram_wdata   = ram_wdata_q;
  assign vid_rvalid  = (tag_q[RD_LAT] == TAG_VID);
  assign cpu_rvalid  = (tag_q[RD_LAT] == TAG_CPU);
  assign vid_rdata   = ram_rdata;
  assign cpu_rdata   = ram_rdata;

endmodule
